// File: rtl/priority_encoder_pkg.sv
// Shared sizing and result type for the 4-input registered priority encoder.
package priority_encoder_pkg;
    localparam int NUM_REQ = 4;
    localparam int IDX_W   = 2;

    typedef struct packed {
        logic               valid;
        logic [IDX_W-1:0]   idx;
        logic [NUM_REQ-1:0] grant;
    } enc_result_t;
endpackage

// File: rtl/priority_encoder_core.sv
// Combinational priority encoder: highest-numbered asserted request wins.
module prio_enc_core #(
    parameter int WIDTH = 4,
    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0] req,
    output logic [IDX_W-1:0] idx,
    output logic             any,
    output logic [WIDTH-1:0] grant
);
    // Scanning upward and overwriting lets the highest set bit win.
    always_comb begin
        idx   = '0;
        grant = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (req[i]) begin
                idx   = IDX_W'(i);
                grant = '0;
                grant[i] = 1'b1;
            end
        end
        any = |req;
    end
endmodule

// File: rtl/priority_encoder.sv
// Registered 4-to-2 priority encoder with one-hot grant and capture enable.
module priority_encoder
    import priority_encoder_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               d3,
    input  logic               d2,
    input  logic               d1,
    input  logic               d0,
    output logic               y1,
    output logic               y0,
    output logic               valid,
    output logic [NUM_REQ-1:0] grant
);
    logic [NUM_REQ-1:0] req;
    enc_result_t        nxt;
    enc_result_t        res;

    assign req = {d3, d2, d1, d0};

    prio_enc_core #(.WIDTH(NUM_REQ)) u_core (
        .req   (req),
        .idx   (nxt.idx),
        .any   (nxt.valid),
        .grant (nxt.grant)
    );

    always_ff @(posedge clk) begin
        if (!rst_n)
            res <= '0;
        else if (en)
            res <= nxt;
    end

    assign y1    = res.idx[1];
    assign y0    = res.idx[0];
    assign valid = res.valid;
    assign grant = res.grant;
endmodule

// File: tb/tb_priority_encoder.sv
// Directed and randomized-sequence checks of the registered priority encoder.
module tb_priority_encoder;
    logic       clk = 1'b0;
    logic       rst_n, en, d3, d2, d1, d0;
    logic       y1, y0, valid;
    logic [3:0] grant;
    int         tests = 0;
    int         fails = 0;

    priority_encoder dut (
        .clk(clk), .rst_n(rst_n), .en(en),
        .d3(d3), .d2(d2), .d1(d1), .d0(d0),
        .y1(y1), .y0(y0), .valid(valid), .grant(grant)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Compare the full output bank {y, valid, grant}.
    task automatic check_out(input string tag, input logic [1:0] ey, input logic ev, input logic [3:0] eg);
        check(tag, {1'b0, y1, y0, valid, grant}, {1'b0, ey, ev, eg});
    endtask

    task automatic set_d(input logic [3:0] v);
        {d3, d2, d1, d0} = v;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference: written as an explicit priority chain.
    function automatic logic [6:0] ref_enc(input logic [3:0] v);
        if (v[3])      return {2'd3, 1'b1, 4'b1000};
        else if (v[2]) return {2'd2, 1'b1, 4'b0100};
        else if (v[1]) return {2'd1, 1'b1, 4'b0010};
        else if (v[0]) return {2'd0, 1'b1, 4'b0001};
        else           return 7'b0;
    endfunction

    initial begin
        logic [6:0] model;
        logic [3:0] v;

        // Reset dominates en with all requests high
        rst_n = 1'b0; en = 1'b1; set_d(4'b1111);
        tick; check_out("reset_edge1", 2'b00, 1'b0, 4'b0000);
        tick; check_out("reset_edge2", 2'b00, 1'b0, 4'b0000);
        rst_n = 1'b1;
        tick; check_out("reset_release", 2'b11, 1'b1, 4'b1000);

        // Single-hot sweep
        set_d(4'b0000); tick; check_out("sweep_0000", 2'b00, 1'b0, 4'b0000);
        set_d(4'b0001); tick; check_out("sweep_0001", 2'b00, 1'b1, 4'b0001);
        set_d(4'b0010); tick; check_out("sweep_0010", 2'b01, 1'b1, 4'b0010);
        set_d(4'b0100); tick; check_out("sweep_0100", 2'b10, 1'b1, 4'b0100);
        set_d(4'b1000); tick; check_out("sweep_1000", 2'b11, 1'b1, 4'b1000);

        // Priority overlap
        set_d(4'b0111); tick; check_out("prio_0111", 2'b10, 1'b1, 4'b0100);
        set_d(4'b0011); tick; check_out("prio_0011", 2'b01, 1'b1, 4'b0010);
        set_d(4'b1010); tick; check_out("prio_1010", 2'b11, 1'b1, 4'b1000);
        set_d(4'b1111); tick; check_out("prio_1111", 2'b11, 1'b1, 4'b1000);

        // Latency: new input not visible until the next edge
        set_d(4'b0001); tick; check_out("lat_before", 2'b00, 1'b1, 4'b0001);
        set_d(4'b0100); #2;   check_out("lat_same_cycle", 2'b00, 1'b1, 4'b0001);
        tick;                 check_out("lat_after", 2'b10, 1'b1, 4'b0100);

        // Enable hold
        set_d(4'b0010); tick; check_out("hold_capture", 2'b01, 1'b1, 4'b0010);
        en = 1'b0; set_d(4'b1000);
        for (int k = 0; k < 3; k++) begin
            tick; check_out("hold_en0", 2'b01, 1'b1, 4'b0010);
        end
        en = 1'b1;
        tick; check_out("hold_release", 2'b11, 1'b1, 4'b1000);

        // All 16 values three times with random enable and reset pulses
        model = {2'd3, 1'b1, 4'b1000};
        for (int i = 0; i < 48; i++) begin
            v     = 4'(i % 16);
            en    = ($urandom_range(0, 3) != 0);
            rst_n = ($urandom_range(0, 7) != 0);
            set_d(v);
            tick;
            if (!rst_n)  model = 7'b0;
            else if (en) model = ref_enc(v);
            check_out("rand_model", model[6:5], model[4], model[3:0]);
            check("rand_onehot0", {7'b0, $onehot0(grant)}, 8'd1);
            check("rand_grant_valid", {7'b0, (grant != 4'b0)}, {7'b0, valid});
            if (valid)
                check("rand_idx_grant", {7'b0, grant[{y1, y0}]}, 8'd1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
